// File: rtl/doppler_spi_pkg.sv
// Shared constants and state encoding for the samd51 <-> ice40 config SPI link.
package doppler_spi_pkg;

    localparam int unsigned SPI_WIDTH     = 16;
    localparam logic [SPI_WIDTH-1:0] SPI_IDLE_WORD = 16'hFFFF;
    localparam int unsigned SYNC_STAGES   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_tx_slave_sync_edge.sv
// Multi-stage synchroniser for an asynchronous SPI pin with registered rise/fall pulses.
module sync_edge
    import doppler_spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_tx_slave.sv
// SPI mode 0 transmit responder: one-entry holding register feeding an MSB-first shifter.
// Define SPI_TX_PARITY_EN to append an odd-parity bit after the payload LSB.
module spi_tx_slave
    import doppler_spi_pkg::*;
#(
    parameter int unsigned      WIDTH     = SPI_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(SPI_IDLE_WORD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_cs,
    input  logic             cfg_sck,
    output logic             cfg_so,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic             abort,
    output logic             underrun
);

`ifdef SPI_TX_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME + 1);

    function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SPI_TX_PARITY_EN
        return {w, ~^w};
`else
        return w;
`endif
    endfunction

    logic cs_rise, cs_fall, sck_rise, sck_fall;

    sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cfg_cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cfg_sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_state_e       state_q, state_d;
    logic [FRAME-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full_q, full_d;
    logic             so_q, so_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             underrun_q, underrun_d;
    logic             accept, load_hold;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        underrun_d = 1'b0;
        load_hold  = 1'b0;
        accept     = tx_valid & ~full_q;

        case (state_q)
            IDLE: begin
                // Frame loads from the holding state as it was before any same-cycle accept.
                if (cs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    if (full_q) begin
                        shift_d   = frame_of(hold_q);
                        load_hold = 1'b1;
                    end else begin
                        shift_d    = frame_of(IDLE_WORD);
                        underrun_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(FRAME - 1)) state_d = DONE;
                    end
                    if (sck_fall) shift_d = {shift_q[FRAME-2:0], 1'b0};
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (sck_fall) begin
                    shift_d = {shift_q[FRAME-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        full_d = accept | (full_q & ~load_hold);
        hold_d = accept ? tx_data : hold_q;
        busy_d = (state_d != IDLE);
        so_d   = (state_d != IDLE) & shift_d[FRAME-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            so_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            so_q       <= so_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            underrun_q <= underrun_d;
        end
    end

    assign cfg_so   = so_q;
    assign tx_ready = ~full_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign abort    = abort_q;
    assign underrun = underrun_q;

endmodule
